// File: rtl/video_in_packetizer.sv
// Drains 4-bit samples from a show-ahead FIFO, packs nibble pairs into bytes and frames them as
// fixed-length packets (magic, sequence number, payload) on a valid/ready byte stream.
module video_in_packetizer #(
    parameter int          PAYLOAD_BYTES = 128,
    parameter int          USEDW_WIDTH   = 9,
    parameter logic [15:0] MAGIC         = 16'hDA7A,
    parameter logic [15:0] SEQ_INIT      = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [3:0]             fifor_data,
    input  logic                   fifor_empty,
    input  logic [USEDW_WIDTH-1:0] fifor_used_words,
    output logic                   fifor_acknowledge,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic [15:0]            seq_num,
    output logic                   pkt_count_wrap
);
    localparam int CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [CNT_W-1:0]       LAST_IDX    = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [USEDW_WIDTH-1:0] START_LEVEL = USEDW_WIDTH'(2 * PAYLOAD_BYTES);

    typedef enum logic [2:0] {IDLE, HDR, PAY_HI, PAY_LO, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [3:0]       hi_q, hi_d;
    logic [1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]      seq_q, seq_d;
    logic             wrap_q, wrap_d;
    logic             ack;
    logic             slot_free;
    logic [7:0]       hdr_byte;

    // The output slot can take a new byte if empty or if its current byte leaves this cycle.
    assign slot_free = !valid_q || tx_ready;

    always_comb begin
        hdr_byte = seq_q[7:0];
        case (hdr_cnt_q)
            2'd0:    hdr_byte = MAGIC[15:8];
            2'd1:    hdr_byte = MAGIC[7:0];
            2'd2:    hdr_byte = seq_q[15:8];
            default: hdr_byte = seq_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hi_d       = hi_q;
        hdr_cnt_d  = hdr_cnt_q;
        byte_cnt_d = byte_cnt_q;
        seq_d      = seq_q;
        wrap_d     = 1'b0;
        ack        = 1'b0;

        if (valid_q && tx_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Start only with a full payload buffered so the payload can never underrun.
                if (enable && fifor_used_words >= START_LEVEL) begin
                    state_d    = HDR;
                    hdr_cnt_d  = 2'd0;
                    byte_cnt_d = '0;
                end
            end
            HDR: begin
                if (slot_free) begin
                    data_d    = hdr_byte;
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        state_d = PAY_HI;
                    end
                end
            end
            PAY_HI: begin
                if (slot_free && !fifor_empty) begin
                    ack     = 1'b1;
                    hi_d    = fifor_data;
                    state_d = PAY_LO;
                end
            end
            PAY_LO: begin
                if (slot_free && !fifor_empty) begin
                    ack        = 1'b1;
                    data_d     = {hi_q, fifor_data};
                    valid_d    = 1'b1;
                    last_d     = (byte_cnt_q == LAST_IDX);
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = (byte_cnt_q == LAST_IDX) ? DONE : PAY_HI;
                end
            end
            DONE: begin
                if (valid_q && tx_ready) begin
                    seq_d   = seq_q + 16'd1;
                    wrap_d  = (seq_q == 16'hFFFF);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            hi_q       <= 4'h0;
            hdr_cnt_q  <= 2'd0;
            byte_cnt_q <= '0;
            seq_q      <= SEQ_INIT;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            hi_q       <= hi_d;
            hdr_cnt_q  <= hdr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            seq_q      <= seq_d;
            wrap_q     <= wrap_d;
        end
    end

    assign fifor_acknowledge = ack;
    assign tx_data           = data_q;
    assign tx_valid          = valid_q;
    assign tx_last           = last_q;
    assign seq_num           = seq_q;
    assign pkt_count_wrap    = wrap_q;

endmodule

// File: tb/tb_video_in_packetizer.sv
// Bench for video_in_packetizer: a 128-byte-payload instance fed by a FIFO model and a small
// 2-byte-payload instance starting near the sequence wrap, fed by an endless nibble source.
`timescale 1ns/1ps
module tb_video_in_packetizer;
    localparam int PB  = 128;
    localparam int UW  = 9;
    localparam int PKT = PB + 4;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic          rst, enable, tx_ready;
    logic [3:0]    fifor_data;
    logic          fifor_empty;
    logic [UW-1:0] fifor_used_words;
    logic          fifor_acknowledge;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_last, pkt_count_wrap;
    logic [15:0]   seq_num;

    logic          rst2, enable2, ready2, empty2;
    logic [3:0]    data2, cnt2;
    logic [2:0]    used2;
    logic          ack2, valid2, last2, wrap2;
    logic [7:0]    txd2;
    logic [15:0]   seq2;

    video_in_packetizer #(.PAYLOAD_BYTES(PB), .USEDW_WIDTH(UW)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifor_data(fifor_data), .fifor_empty(fifor_empty), .fifor_used_words(fifor_used_words),
        .fifor_acknowledge(fifor_acknowledge),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .seq_num(seq_num), .pkt_count_wrap(pkt_count_wrap)
    );

    video_in_packetizer #(.PAYLOAD_BYTES(2), .USEDW_WIDTH(3), .SEQ_INIT(16'hFFFE)) u_dut2 (
        .clk(clk), .rst(rst2), .enable(enable2),
        .fifor_data(data2), .fifor_empty(empty2), .fifor_used_words(used2),
        .fifor_acknowledge(ack2),
        .tx_data(txd2), .tx_valid(valid2), .tx_ready(ready2), .tx_last(last2),
        .seq_num(seq2), .pkt_count_wrap(wrap2)
    );

    // FIFO model for the main instance; a bench reset flushes it.
    logic [3:0] mem [0:511];
    int         wr_ptr = 0, rd_ptr = 0, occ;
    logic       push_en;
    logic [3:0] push_nib;
    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (fifor_acknowledge) rd_ptr <= rd_ptr + 1;
        if (push_en) begin
            mem[wr_ptr % 512] <= push_nib;
            wr_ptr <= wr_ptr + 1;
        end
    end
    always_comb begin
        occ              = wr_ptr - rd_ptr;
        fifor_empty      = (occ == 0);
        fifor_used_words = (occ > 511) ? 9'd511 : occ[8:0];
        fifor_data       = mem[rd_ptr % 512];
    end

    always @(posedge clk) begin
        if (rst2) cnt2 <= 4'h0;
        else if (ack2) cnt2 <= cnt2 + 4'h1;
    end
    assign data2 = cnt2;

    typedef struct packed {logic [7:0] data; logic last; logic [31:0] cyc;} beat_t;
    beat_t       rx_q[$];
    beat_t       rx2_q[$];
    logic [31:0] cyc = 0;
    int ack_cnt = 0, ack_empty_viol = 0, valid_cnt = 0, stall_viol = 0;
    int wrap_cnt = 0, wrap_bad = 0;
    logic       stall_prev = 1'b0, stall_last = 1'b0, acc_last2_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample half a cycle ahead of the edge where the handshake will be taken.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && (!tx_valid || tx_data != stall_data || tx_last != stall_last))
                stall_viol <= stall_viol + 1;
            stall_prev <= tx_valid && !tx_ready;
            stall_data <= tx_data;
            stall_last <= tx_last;
            if (tx_valid) valid_cnt <= valid_cnt + 1;
            if (tx_valid && tx_ready) rx_q.push_back({tx_data, tx_last, cyc});
            if (fifor_acknowledge) ack_cnt <= ack_cnt + 1;
            if (fifor_acknowledge && fifor_empty) ack_empty_viol <= ack_empty_viol + 1;
        end
        if (!rst2) begin
            if (valid2 && ready2 && rx2_q.size() < 32) rx2_q.push_back({txd2, last2, cyc});
            if (wrap2) begin
                wrap_cnt <= wrap_cnt + 1;
                if (seq2 != 16'h0000 || !acc_last2_prev) wrap_bad <= wrap_bad + 1;
            end
            acc_last2_prev <= valid2 && ready2 && last2;
        end
    end

    int n_checks = 0, n_pass = 0, nib_ctr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [15:0] seq);
        int k;
        case (i)
            0: return 8'hDA;
            1: return 8'h7A;
            2: return seq[15:8];
            3: return seq[7:0];
            default: begin
                k = i - 4;
                return {4'((2 * k) % 16), 4'((2 * k + 1) % 16)};
            end
        endcase
    endfunction

    task automatic check_pkt(input string name, input int base, input logic [15:0] seq);
        int errs = 0;
        logic [8:0] got, exp;
        for (int i = 0; i < PKT; i++) begin
            exp = {exp_byte(i, seq), (i == PKT - 1)};
            got = (base + i < rx_q.size()) ? {rx_q[base + i].data, rx_q[base + i].last} : 9'bx;
            if (got !== exp) begin
                if (errs == 0) $display("  %s first diff at byte %0d: got %h want %h", name, i, got, exp);
                errs++;
            end
        end
        check(name, errs, 0);
    endtask

    task automatic push_n(input int n);
        int guard = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (wr_ptr - rd_ptr >= 510 && guard < 5000) begin
                push_en = 1'b0;
                guard++;
                @(negedge clk);
            end
            push_en  = 1'b1;
            push_nib = 4'(nib_ctr % 16);
            nib_ctr++;
        end
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct packed {int idx; logic [7:0] data; logic last;} vec_t;

    logic t3_done = 1'b0;

    initial begin
        logic ok;
        int   base, a0, v0, s0, lasts;
        vec_t vecs[10];
        vec_t vecs2[18];
        vecs = '{'{0, 8'hDA, 1'b0}, '{1, 8'h7A, 1'b0}, '{2, 8'h00, 1'b0}, '{3, 8'h00, 1'b0},
                 '{4, 8'h01, 1'b0}, '{5, 8'h23, 1'b0}, '{11, 8'hEF, 1'b0}, '{12, 8'h01, 1'b0},
                 '{130, 8'hCD, 1'b0}, '{131, 8'hEF, 1'b1}};
        vecs2 = '{'{0, 8'hDA, 1'b0}, '{1, 8'h7A, 1'b0}, '{2, 8'hFF, 1'b0}, '{3, 8'hFE, 1'b0},
                  '{4, 8'h01, 1'b0}, '{5, 8'h23, 1'b1},
                  '{6, 8'hDA, 1'b0}, '{7, 8'h7A, 1'b0}, '{8, 8'hFF, 1'b0}, '{9, 8'hFF, 1'b0},
                  '{10, 8'h45, 1'b0}, '{11, 8'h67, 1'b1},
                  '{12, 8'hDA, 1'b0}, '{13, 8'h7A, 1'b0}, '{14, 8'h00, 1'b0}, '{15, 8'h00, 1'b0},
                  '{16, 8'h89, 1'b0}, '{17, 8'hAB, 1'b1}};

        rst = 1'b1; rst2 = 1'b1; enable = 1'b0; tx_ready = 1'b1; push_en = 1'b0; push_nib = 4'h0;
        enable2 = 1'b1; ready2 = 1'b1; empty2 = 1'b0; used2 = 3'd7;
        repeat (3) @(negedge clk);
        #1;
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_data", tx_data, 0);
        check("reset tx_last", tx_last, 0);
        check("reset ack", fifor_acknowledge, 0);
        check("reset seq_num", seq_num, 0);
        check("reset wrap", pkt_count_wrap, 0);
        check("reset seq_num2", seq2, 16'hFFFE);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // Packet from a fully preloaded FIFO with tx_ready held high.
        push_n(256);
        a0 = ack_cnt;
        enable = 1'b1;
        wait_rx(PKT, 2000, ok);
        check("t1 complete", ok, 1);
        repeat (3) @(negedge clk);
        foreach (vecs[i])
            check($sformatf("t1 byte%0d", vecs[i].idx),
                  {rx_q[vecs[i].idx].data, rx_q[vecs[i].idx].last}, {vecs[i].data, vecs[i].last});
        check_pkt("t1 stream", 0, 16'h0000);
        check("t1 header back-to-back", rx_q[3].cyc - rx_q[0].cyc, 3);
        check("t1 duration", rx_q[PKT - 1].cyc - rx_q[0].cyc, 259);
        check("t1 seq_num", seq_num, 1);
        check("t1 ack count", ack_cnt - a0, 256);

        // One nibble short of a payload: nothing starts until the last nibble lands.
        base = rx_q.size(); a0 = ack_cnt; v0 = valid_cnt;
        push_n(255);
        repeat (20) @(negedge clk);
        check("t2 no valid at 255", valid_cnt - v0, 0);
        check("t2 no ack at 255", ack_cnt - a0, 0);
        @(negedge clk);
        push_en = 1'b1; push_nib = 4'(nib_ctr % 16); nib_ctr++;
        @(negedge clk);
        push_en = 1'b0;
        #1 check("t2 valid +0", tx_valid, 0);
        @(negedge clk);
        #1 check("t2 valid +1", tx_valid, 0);
        @(negedge clk);
        #1 check("t2 first hdr +2", {tx_valid, tx_data}, {1'b1, 8'hDA});
        wait_rx(base + PKT, 2000, ok);
        check("t2 complete", ok, 1);
        check_pkt("t2 stream", base, 16'h0001);

        // Enable dropped mid-packet: packet completes, then nothing new despite a loaded FIFO.
        base = rx_q.size();
        push_n(256);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        check("t6 started", tx_valid, 1);
        enable = 1'b0;
        push_n(300);
        wait_rx(base + PKT, 2000, ok);
        check("t6 complete", ok, 1);
        repeat (3) @(negedge clk);
        check_pkt("t6 stream", base, 16'h0002);
        v0 = valid_cnt;
        repeat (100) @(negedge clk);
        check("t6 idle while disabled", valid_cnt - v0, 0);
        check("t6 seq_num", seq_num, 3);

        // Reset in the middle of a payload.
        base = rx_q.size();
        enable = 1'b1;
        wait_rx(base + 44, 2000, ok);
        check("t4 reached byte 40", ok, 1);
        rst = 1'b1;
        nib_ctr = 0;
        #1;
        check("t4 rst tx_valid", tx_valid, 0);
        check("t4 rst tx_data", tx_data, 0);
        check("t4 rst tx_last", tx_last, 0);
        check("t4 rst ack", fifor_acknowledge, 0);
        check("t4 rst seq_num", seq_num, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lasts = 0;
        for (int i = base; i < rx_q.size(); i++) lasts += int'(rx_q[i].last);
        check("t4 no tx_last in aborted pkt", lasts, 0);

        // Three packets with random backpressure while the FIFO is being filled.
        base = rx_q.size(); a0 = ack_cnt; s0 = stall_viol;
        fork
            push_n(768);
            begin
                while (!t3_done) begin
                    @(negedge clk);
                    tx_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                wait_rx(base + 3 * PKT, 20000, ok);
                t3_done = 1'b1;
            end
        join
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t3 complete", ok, 1);
        check_pkt("t3 pkt0", base, 16'h0000);
        check_pkt("t3 pkt1", base + PKT, 16'h0001);
        check_pkt("t3 pkt2", base + 2 * PKT, 16'h0002);
        check("t3 data stable under stall", stall_viol - s0, 0);
        check("t3 ack count", ack_cnt - a0, 768);
        check("ack while empty", ack_empty_viol, 0);

        // Small instance started at 0xFFFE: headers FFFE, FFFF, 0000 and exactly one wrap pulse.
        foreach (vecs2[i])
            check($sformatf("t5 byte%0d", vecs2[i].idx),
                  {rx2_q[vecs2[i].idx].data, rx2_q[vecs2[i].idx].last}, {vecs2[i].data, vecs2[i].last});
        check("t5 wrap pulses", wrap_cnt, 1);
        check("t5 wrap timing", wrap_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
